// File: rtl/keypad_button_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : keypad_button_encoder
// Description : Scans a 4x4 matrix keypad one row at a time, debounces the
//               scanned frames and emits one 10-bit button code per accepted
//               key press as a single-cycle strobe. Chords are rejected and
//               there is no auto-repeat.
// Ports       : clk           - system clock
//               rst           - synchronous active-high reset
//               row_n[3:0]    - row drive, active-low, one row low at a time
//               col_n[3:0]    - column sense, active-low, asynchronous
//               button[9:0]   - button code, nonzero only in the strobe cycle
//               button_strobe - one-cycle pulse qualifying button
//               key_held      - high from accepted press to accepted release
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_button_encoder #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [9:0] button,
    output logic       button_strobe,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    // Sequential state
    logic [3:0]       col_s1_q, col_s2_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       row_q;
    logic [11:0]      keymap_q;   // rows 0..2; row 3 is taken live at frame end
    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       rcnt_q, rcnt_d;
    logic             held_q, held_d;
    logic [9:0]       button_q, button_d;
    logic             strobe_q, strobe_d;

    // Combinational helpers
    logic        w_slot_end;
    logic        w_frame_end;
    logic [15:0] w_frame;
    logic        w_single;
    logic [3:0]  w_idx;
    logic        w_accept;

    function automatic logic [9:0] key_code(input logic [3:0] idx);
        logic [9:0] code;
        case (idx)
            4'd0:    code = 10'b00_0000_0010; // 1
            4'd1:    code = 10'b00_0000_0100; // 2
            4'd2:    code = 10'b00_0000_1000; // 3
            4'd3:    code = 10'b10_0000_0001; // +
            4'd4:    code = 10'b00_0001_0000; // 4
            4'd5:    code = 10'b00_0010_0000; // 5
            4'd6:    code = 10'b00_0100_0000; // 6
            4'd7:    code = 10'b10_0000_0010; // -
            4'd8:    code = 10'b00_1000_0000; // 7
            4'd9:    code = 10'b01_0000_0000; // 8
            4'd10:   code = 10'b01_0000_0001; // 9
            4'd11:   code = 10'b10_0000_0100; // *
            4'd12:   code = 10'b11_1000_0000; // C
            4'd13:   code = 10'b00_0000_0001; // 0
            4'd14:   code = 10'b11_0000_0000; // =
            default: code = 10'b10_0000_1000; // /
        endcase
        return code;
    endfunction

    assign w_slot_end  = (div_q == DIV_W'(SCAN_DIV - 1));
    assign w_frame_end = w_slot_end && (row_q == 2'd3);
    // Completed frame: stored rows 0..2 plus the row-3 sample taken this cycle
    assign w_frame     = {~col_s2_q, keymap_q};
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero
    assign w_single    = (w_frame != 16'd0) && ((w_frame & (w_frame - 16'd1)) == 16'd0);

    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    assign row_n         = ~(4'b0001 << row_q);
    assign button        = button_q;
    assign button_strobe = strobe_q;
    assign key_held      = held_q;

    // Synchronizer, row scan and keymap capture
    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1_q <= 4'b1111;
            col_s2_q <= 4'b1111;
            div_q    <= '0;
            row_q    <= 2'd0;
            keymap_q <= '0;
        end else begin
            col_s1_q <= col_n;
            col_s2_q <= col_s1_q;
            if (w_slot_end) begin
                div_q <= '0;
                row_q <= row_q + 2'd1;
                case (row_q)
                    2'd0:    keymap_q[3:0]  <= ~col_s2_q;
                    2'd1:    keymap_q[7:4]  <= ~col_s2_q;
                    2'd2:    keymap_q[11:8] <= ~col_s2_q;
                    default: keymap_q       <= keymap_q;
                endcase
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // FSM state register and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cand_q   <= 4'd0;
            cnt_q    <= 8'd0;
            rcnt_q   <= 8'd0;
            held_q   <= 1'b0;
            button_q <= 10'd0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            rcnt_q   <= rcnt_d;
            held_q   <= held_d;
            button_q <= button_d;
            strobe_q <= strobe_d;
        end
    end

    // Next-state logic: only acts on the frame-end cycle
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        held_d   = held_q;
        w_accept = 1'b0;

        if (w_frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_single) begin
                        cand_d = w_idx;
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_accept = 1'b1;
                            held_d   = 1'b1;
                            rcnt_d   = 8'd0;
                            cnt_d    = 8'd0;
                            state_d  = ST_HELD;
                        end else begin
                            cnt_d   = 8'd1;
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_single && (w_idx == cand_q)) begin
                        if (({1'b0, cnt_q} + 9'd1) == 9'(DEBOUNCE_FRAMES)) begin
                            w_accept = 1'b1;
                            held_d   = 1'b1;
                            rcnt_d   = 8'd0;
                            cnt_d    = 8'd0;
                            state_d  = ST_HELD;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (w_frame == 16'd0) begin
                        if (({1'b0, rcnt_q} + 9'd1) == 9'(DEBOUNCE_FRAMES)) begin
                            rcnt_d  = 8'd0;
                            held_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            rcnt_d = rcnt_q + 8'd1;
                        end
                    end else begin
                        rcnt_d = 8'd0;
                    end
                end
                default: begin
                    cnt_d   = 8'd0;
                    rcnt_d  = 8'd0;
                    held_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Accepting frame's key is the candidate, so the live index is valid
        button_d = w_accept ? key_code(w_idx) : 10'd0;
        strobe_d = w_accept;
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_button_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_keypad_button_encoder
// Description : Self-checking bench for keypad_button_encoder with a
//               behavioural 4x4 keypad model. SCAN_DIV=4, DEBOUNCE_FRAMES=2,
//               so one frame is 16 clock cycles. A table of single-key
//               presses covers the full code table; hand-written sequences
//               cover reset, release timing, chords, bounce and mid-press
//               reset.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_button_encoder;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_FRAMES = 2;
    localparam int FRAME           = 4 * SCAN_DIV;

    logic       clk;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [9:0] button;
    logic       button_strobe;
    logic       key_held;

    logic [15:0] keys;   // keys[4*row+col] = 1 when pressed

    keypad_button_encoder #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .row_n        (row_n),
        .col_n        (col_n),
        .button       (button),
        .button_strobe(button_strobe),
        .key_held     (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its column to the row that is driven low
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[r] && keys[4*r+c]) begin
                    col_n[c] = 1'b0;
                end
            end
        end
    end

    // Edge index since the last reset edge
    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Strobe monitor and pulse-shape invariants
    int         ev_total;
    int         viol;
    logic [9:0] ev_code [64];
    int         ev_cyc  [64];
    logic       prev_s;
    initial begin
        ev_total = 0;
        viol     = 0;
        prev_s   = 1'b0;
    end
    always @(negedge clk) begin
        if (rst) begin
            prev_s <= 1'b0;
        end else begin
            if (button_strobe) begin
                ev_code[ev_total % 64] <= button;
                ev_cyc[ev_total % 64]  <= cyc;
                ev_total               <= ev_total + 1;
                if (prev_s || button == 10'd0) viol <= viol + 1;
            end else if (button != 10'd0) begin
                viol <= viol + 1;
            end
            prev_s <= button_strobe;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic align_frame();
        @(negedge clk);
        while (cyc % FRAME != 0) @(negedge clk);
    endtask

    typedef struct {
        int         idx;
        int         press;
        logic [9:0] code;
    } vec_t;

    vec_t vecs [16];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int start;
        int rel;

        vecs[0]  = '{5,  5, 10'b00_0010_0000}; // 5, held 5 frames
        vecs[1]  = '{3,  4, 10'b10_0000_0001}; // +
        vecs[2]  = '{14, 4, 10'b11_0000_0000}; // =
        vecs[3]  = '{12, 4, 10'b11_1000_0000}; // C
        vecs[4]  = '{0,  4, 10'b00_0000_0010}; // 1
        vecs[5]  = '{1,  4, 10'b00_0000_0100}; // 2
        vecs[6]  = '{2,  3, 10'b00_0000_1000}; // 3
        vecs[7]  = '{4,  4, 10'b00_0001_0000}; // 4
        vecs[8]  = '{6,  4, 10'b00_0100_0000}; // 6
        vecs[9]  = '{7,  4, 10'b10_0000_0010}; // -
        vecs[10] = '{8,  4, 10'b00_1000_0000}; // 7
        vecs[11] = '{9,  4, 10'b01_0000_0000}; // 8
        vecs[12] = '{10, 4, 10'b01_0000_0001}; // 9
        vecs[13] = '{11, 4, 10'b10_0000_0100}; // *
        vecs[14] = '{13, 4, 10'b00_0000_0001}; // 0
        vecs[15] = '{15, 2, 10'b10_0000_1000}; // /

        keys = 16'd0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state, then two idle frames of row scanning
        chk("reset_key_held", 32'(key_held), 32'd0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            chk("idle_scan", {18'd0, row_n, button_strobe, button[8:0]} | (32'(button[9]) << 10),
                {18'd0, ~(4'b0001 << ((cyc / SCAN_DIV) % 4)), 10'd0});
            @(negedge clk);
        end

        // Single-key table
        for (int v = 0; v < 16; v++) begin
            align_frame();
            start = cyc;
            base  = ev_total;
            keys  = 16'd1 << vecs[v].idx;
            run_frames(vecs[v].press);
            keys  = 16'd0;
            run_frames(4);
            chk($sformatf("count_k%0d", vecs[v].idx), 32'(ev_total - base), 32'd1);
            chk($sformatf("code_k%0d", vecs[v].idx), 32'(ev_code[base % 64]), 32'(vecs[v].code));
            chk($sformatf("when_k%0d", vecs[v].idx), 32'(ev_cyc[base % 64]), 32'(start + 2 * FRAME));
            chk($sformatf("held_off_k%0d", vecs[v].idx), 32'(key_held), 32'd0);
        end

        // Key "5": key_held rise and fall timing
        align_frame();
        start = cyc;
        keys  = 16'd1 << 5;
        repeat (2 * FRAME - 1) @(negedge clk);
        chk("held_before_accept", 32'(key_held), 32'd0);
        @(negedge clk);
        chk("held_at_accept", 32'(key_held), 32'd1);
        while (cyc < start + 5 * FRAME) @(negedge clk);
        rel  = cyc;
        keys = 16'd0;
        repeat (2 * FRAME - 1) @(negedge clk);
        chk("held_before_release", 32'(key_held), 32'd1);
        @(negedge clk);
        chk("held_after_release", 32'(key_held), 32'd0);
        chk("release_cycle", 32'(cyc - rel), 32'(2 * FRAME));
        run_frames(1);

        // Chord 8+9 rejected, then releasing 9 accepts 8
        align_frame();
        base = ev_total;
        keys = (16'd1 << 9) | (16'd1 << 10);
        run_frames(6);
        chk("chord_count", 32'(ev_total - base), 32'd0);
        chk("chord_held", 32'(key_held), 32'd0);
        start = cyc;
        keys  = 16'd1 << 9;
        run_frames(4);
        keys  = 16'd0;
        run_frames(4);
        chk("chord_then_8_count", 32'(ev_total - base), 32'd1);
        chk("chord_then_8_code", 32'(ev_code[base % 64]), 32'(10'b01_0000_0000));
        chk("chord_then_8_when", 32'(ev_cyc[base % 64]), 32'(start + 2 * FRAME));

        // Bounce on "3": present, absent, present, absent
        align_frame();
        base = ev_total;
        keys = 16'd1 << 2; run_frames(1);
        keys = 16'd0;      run_frames(1);
        keys = 16'd1 << 2; run_frames(1);
        keys = 16'd0;      run_frames(2);
        chk("bounce_count", 32'(ev_total - base), 32'd0);
        chk("bounce_held", 32'(key_held), 32'd0);
        align_frame();
        start = cyc;
        keys  = 16'd1 << 2;
        run_frames(4);
        keys  = 16'd0;
        run_frames(4);
        chk("bounce_steady_count", 32'(ev_total - base), 32'd1);
        chk("bounce_steady_code", 32'(ev_code[base % 64]), 32'(10'b00_0000_1000));

        // Reset while "/" is held
        align_frame();
        keys = 16'd1 << 15;
        run_frames(4);
        chk("pre_reset_held", 32'(key_held), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_row_n", 32'(row_n), 32'b1110);
        chk("mid_reset_outputs", {20'd0, key_held, button_strobe, button}, 32'd0);
        rst  = 1'b0;
        base = ev_total;
        run_frames(3);
        chk("post_reset_count", 32'(ev_total - base), 32'd1);
        chk("post_reset_code", 32'(ev_code[base % 64]), 32'(10'b10_0000_1000));
        chk("post_reset_when", 32'(ev_cyc[base % 64]), 32'(2 * FRAME));
        keys = 16'd0;
        run_frames(4);
        chk("post_reset_released", 32'(key_held), 32'd0);

        chk("pulse_invariants", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
